// File: rtl/hdmi_sprite_pkg.sv
// Shared constants and state encoding for the HDMI sprite tracker.
package hdmi_sprite_pkg;

    // Coordinate width and position-word field layout.
    localparam int unsigned COORD_W  = 11;
    localparam int unsigned X_LSB    = 0;
    localparam int unsigned Y_LSB    = 16;
    localparam int unsigned SNAP_BIT = 30;
    localparam int unsigned VIS_BIT  = 31;

    typedef enum logic {
        S_IDLE,
        S_UPDATE
    } state_t;

endpackage

// File: rtl/sprite_axis_stepper.sv
// Per-axis next-position logic: snap, teleport, or a clamped glide toward the target.
module sprite_axis_stepper #(
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned STEP        = 2
) (
    input  logic [COORD_W-1:0] i_cur,
    input  logic [COORD_W-1:0] i_tgt,
    input  logic               i_snap,
    output logic [COORD_W-1:0] o_next
);

    localparam logic [COORD_W:0]   TELEPORT = (COORD_W + 1)'(8 * SPRITE_SIZE);
    localparam logic [COORD_W:0]   STEP_W   = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);

    logic [COORD_W:0] w_diff;
    logic [COORD_W:0] w_abs;
    logic             w_neg;

    // Signed difference one bit wider than a coordinate, so it never wraps.
    always_comb begin
        w_diff = {1'b0, i_tgt} - {1'b0, i_cur};
        w_neg  = w_diff[COORD_W];
        w_abs  = w_neg ? (~w_diff + 1'b1) : w_diff;
        // A remaining distance within one step lands exactly on target (no overshoot).
        if (i_snap || (w_abs > TELEPORT) || (w_abs <= STEP_W)) begin
            o_next = i_tgt;
        end else if (w_neg) begin
            o_next = i_cur - STEP_C;
        end else begin
            o_next = i_cur + STEP_C;
        end
    end

endmodule

// File: rtl/hdmi_sprite_tracker.sv
// Tracks the CPU-written Pac-Man position once per frame, glides the sprite toward it,
// steps the mouth animation, and flags scan pixels that land inside the sprite box.
module hdmi_sprite_tracker
    import hdmi_sprite_pkg::*;
#(
    parameter int unsigned COORD_W     = hdmi_sprite_pkg::COORD_W,
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned STEP        = 2,
    parameter int unsigned ANIM_DIV    = 8,
    localparam int unsigned SPR_W      = $clog2(SPRITE_SIZE)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_position,
    input  logic               i_frame_start,
    input  logic               i_pix_valid,
    input  logic [COORD_W-1:0] i_pix_x,
    input  logic [COORD_W-1:0] i_pix_y,
    output logic               o_sprite_on,
    output logic [SPR_W-1:0]   o_sprite_col,
    output logic [SPR_W-1:0]   o_sprite_row,
    output logic [1:0]         o_anim_phase,
    output logic [COORD_W-1:0] o_cur_x,
    output logic [COORD_W-1:0] o_cur_y,
    output logic               o_moving
);

    localparam int unsigned ANIM_CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [ANIM_CW-1:0] ANIM_LAST = ANIM_CW'(ANIM_DIV - 1);
    localparam logic [COORD_W:0]   SIZE_W    = (COORD_W + 1)'(SPRITE_SIZE);

    state_t             r_state;
    logic [COORD_W-1:0] r_tgt_x;
    logic [COORD_W-1:0] r_tgt_y;
    logic               r_snap;
    logic               r_visible;
    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;
    logic               r_moving;
    logic [ANIM_CW-1:0] r_anim_cnt;
    logic [1:0]         r_anim_phase;
    logic               r_sprite_on;
    logic [SPR_W-1:0]   r_sprite_col;
    logic [SPR_W-1:0]   r_sprite_row;

    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;
    logic [COORD_W:0]   w_x_end;
    logic [COORD_W:0]   w_y_end;
    logic               w_hit;
    logic               w_unused_pos;

    // Only the coordinate, snap and visible fields of the PIO word matter.
    assign w_unused_pos = ^{i_position[15:COORD_W], i_position[29:Y_LSB+COORD_W]};

    sprite_axis_stepper #(
        .COORD_W     (COORD_W),
        .SPRITE_SIZE (SPRITE_SIZE),
        .STEP        (STEP)
    ) u_step_x (
        .i_cur  (r_cur_x),
        .i_tgt  (r_tgt_x),
        .i_snap (r_snap),
        .o_next (w_next_x)
    );

    sprite_axis_stepper #(
        .COORD_W     (COORD_W),
        .SPRITE_SIZE (SPRITE_SIZE),
        .STEP        (STEP)
    ) u_step_y (
        .i_cur  (r_cur_y),
        .i_tgt  (r_tgt_y),
        .i_snap (r_snap),
        .o_next (w_next_y)
    );

    // Frame FSM: sample the PIO word at frame_start, move cur on the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_tgt_x      <= '0;
            r_tgt_y      <= '0;
            r_snap       <= 1'b0;
            r_visible    <= 1'b0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_moving     <= 1'b0;
            r_anim_cnt   <= '0;
            r_anim_phase <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_tgt_x   <= i_position[X_LSB +: COORD_W];
                        r_tgt_y   <= i_position[Y_LSB +: COORD_W];
                        r_snap    <= i_position[SNAP_BIT];
                        r_visible <= i_position[VIS_BIT];
                        // Animation advances on frames that begin while still moving.
                        if (r_moving) begin
                            if (r_anim_cnt == ANIM_LAST) begin
                                r_anim_cnt   <= '0;
                                r_anim_phase <= r_anim_phase + 2'd1;
                            end else begin
                                r_anim_cnt <= r_anim_cnt + 1'b1;
                            end
                        end
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // A frame_start arriving here is deliberately dropped.
                    r_cur_x  <= w_next_x;
                    r_cur_y  <= w_next_y;
                    r_moving <= (w_next_x != r_tgt_x) || (w_next_y != r_tgt_y);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Box compare with widened end coordinates so a sprite near the edge clips, never wraps.
    always_comb begin
        w_x_end = {1'b0, r_cur_x} + SIZE_W;
        w_y_end = {1'b0, r_cur_y} + SIZE_W;
        w_hit   = r_visible && i_pix_valid &&
                  (i_pix_x >= r_cur_x) && ({1'b0, i_pix_x} < w_x_end) &&
                  (i_pix_y >= r_cur_y) && ({1'b0, i_pix_y} < w_y_end);
    end

    // Hit register stage: one cycle of latency toward the sprite ROM/mixer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sprite_on  <= 1'b0;
            r_sprite_col <= '0;
            r_sprite_row <= '0;
        end else begin
            r_sprite_on  <= w_hit;
            r_sprite_col <= w_hit ? (i_pix_x[SPR_W-1:0] - r_cur_x[SPR_W-1:0]) : '0;
            r_sprite_row <= w_hit ? (i_pix_y[SPR_W-1:0] - r_cur_y[SPR_W-1:0]) : '0;
        end
    end

    assign o_sprite_on  = r_sprite_on;
    assign o_sprite_col = r_sprite_col;
    assign o_sprite_row = r_sprite_row;
    assign o_anim_phase = r_anim_phase;
    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;
    assign o_moving     = r_moving;

endmodule
